// File: rtl/vending_dispense_ctrl.sv
// vending_dispense_ctrl: coin credit, product vend handshake with timeout refund, and paced change return.
module vending_dispense_ctrl #(
    parameter int PRICE_A    = 3,
    parameter int PRICE_B    = 4,
    parameter int CREDIT_MAX = 12,
    parameter int TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] coin,
    input  logic [1:0] sel,
    input  logic       cancel,
    input  logic       vend_ack,
    output logic       vend_req,
    output logic       change_pulse,
    output logic       coin_reject,
    output logic       fault,
    output logic [3:0] credit,
    output logic       busy
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;
    state_t state_q, state_d;
    logic [3:0] credit_q, credit_d, price_q, price_d, sel_price;
    logic [TW-1:0] tmr_q, tmr_d;
    logic vend_req_q, vend_req_d, change_q, change_d, reject_q, reject_d;
    logic fault_q, fault_d, busy_q, busy_d;
    logic coin_v, sel_v;
    logic [4:0] coin_sum;
    assign coin_v    = coin == 2'b01 || coin == 2'b10;
    assign sel_v     = sel == 2'b01 || sel == 2'b10;
    assign sel_price = sel == 2'b01 ? 4'(PRICE_A) : 4'(PRICE_B);
    assign coin_sum  = {1'b0, credit_q} + (coin == 2'b10 ? 5'd2 : 5'd1);
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        price_d    = price_q;
        tmr_d      = tmr_q;
        vend_req_d = vend_req_q;
        change_d   = 1'b0;
        reject_d   = 1'b0;
        fault_d    = 1'b0;
        case (state_q)
            IDLE, CREDIT: begin
                if (cancel && state_q == CREDIT) begin
                    state_d  = CHANGE;
                    reject_d = coin_v;
                end else if (sel_v && state_q == CREDIT && credit_q >= sel_price) begin
                    state_d    = VEND;
                    credit_d   = credit_q - sel_price;
                    price_d    = sel_price;
                    tmr_d      = '0;
                    vend_req_d = 1'b1;
                    reject_d   = coin_v;
                end else if (coin_v) begin
                    if (coin_sum > 5'(CREDIT_MAX)) reject_d = 1'b1;
                    else begin
                        credit_d = coin_sum[3:0];
                        state_d  = CREDIT;
                    end
                end
            end
            VEND: begin
                reject_d = coin_v;
                if (vend_ack) begin
                    vend_req_d = 1'b0;
                    state_d    = credit_q != 0 ? CHANGE : IDLE;
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    // dispenser never answered: refund the whole price through change
                    vend_req_d = 1'b0;
                    fault_d    = 1'b1;
                    credit_d   = credit_q + price_q;
                    state_d    = CHANGE;
                end else tmr_d = tmr_q + 1'b1;
            end
            CHANGE: begin
                reject_d = coin_v;
                if (!change_q && credit_q != 0) begin
                    change_d = 1'b1;
                    credit_d = credit_q - 1'b1;
                end else if (credit_q == 0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d == VEND || state_d == CHANGE;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            price_q    <= '0;
            tmr_q      <= '0;
            vend_req_q <= 1'b0;
            change_q   <= 1'b0;
            reject_q   <= 1'b0;
            fault_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            price_q    <= price_d;
            tmr_q      <= tmr_d;
            vend_req_q <= vend_req_d;
            change_q   <= change_d;
            reject_q   <= reject_d;
            fault_q    <= fault_d;
            busy_q     <= busy_d;
        end
    end
    assign vend_req     = vend_req_q;
    assign change_pulse = change_q;
    assign coin_reject  = reject_q;
    assign fault        = fault_q;
    assign credit       = credit_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_vending_dispense_ctrl.sv
// tb_vending_dispense_ctrl: directed checks of credit, vend, timeout, cancel priority and reset.
module tb_vending_dispense_ctrl;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] coin = 2'b00;
    logic [1:0] sel = 2'b00;
    logic       cancel = 1'b0;
    logic       vend_ack = 1'b0;
    logic       vend_req, change_pulse, coin_reject, fault, busy;
    logic [3:0] credit;
    int errors = 0;
    int checks = 0;
    vending_dispense_ctrl dut (
        .clk(clk), .rstn(rstn), .coin(coin), .sel(sel), .cancel(cancel),
        .vend_ack(vend_ack), .vend_req(vend_req), .change_pulse(change_pulse),
        .coin_reject(coin_reject), .fault(fault), .credit(credit), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask
    task automatic put_coin(input logic [1:0] c);
        coin = c;
        tick();
        coin = 2'b00;
    endtask
    task automatic drain(input string tag, input int exp_n);
        int n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (change_pulse) n++;
            if (!busy) break;
        end
        chk({tag, "_pulses"}, n, exp_n);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_credit0"}, credit, 0);
    endtask
    initial begin
        tick();
        tick();
        chk("rst_credit", credit, 0);
        chk("rst_outs", {vend_req, change_pulse, coin_reject, fault, busy}, 0);
        rstn = 1'b1;
        put_coin(2'b01);
        chk("c1_credit1", credit, 1);
        put_coin(2'b10);
        put_coin(2'b10);
        chk("c1_credit5", credit, 5);
        sel = 2'b01;
        tick();
        sel = 2'b00;
        chk("c1_vreq", vend_req, 1);
        chk("c1_credit2", credit, 2);
        chk("c1_busy", busy, 1);
        tick();
        tick();
        chk("c1_vreq_hold", vend_req, 1);
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
        chk("c1_vreq_drop", vend_req, 0);
        chk("c1_change_entry", {busy, change_pulse}, 2'b10);
        tick();
        chk("c1_p1", {change_pulse, credit}, {1'b1, 4'd1});
        tick();
        chk("c1_gap", {change_pulse, credit}, {1'b0, 4'd1});
        tick();
        chk("c1_p2", {change_pulse, credit}, {1'b1, 4'd0});
        tick();
        chk("c1_idle", {busy, change_pulse}, 0);
        for (int i = 0; i < 6; i++) put_coin(2'b10);
        chk("c2_credit12", credit, 12);
        put_coin(2'b01);
        chk("c2_reject", coin_reject, 1);
        chk("c2_credit_hold", credit, 12);
        tick();
        chk("c2_reject_end", coin_reject, 0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        drain("c2", 12);
        put_coin(2'b10);
        sel = 2'b10;
        tick();
        sel = 2'b00;
        chk("c3_sel_ignored", {vend_req, busy, credit}, {2'b00, 4'd2});
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
        chk("c3_ack_ignored", {busy, credit}, {1'b0, 4'd2});
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("c3_cancel", {busy, credit}, {1'b1, 4'd2});
        drain("c3", 2);
        put_coin(2'b10);
        put_coin(2'b10);
        sel = 2'b10;
        tick();
        sel = 2'b00;
        chk("c4_vend", {vend_req, credit}, {1'b1, 4'd0});
        put_coin(2'b10);
        chk("c4_vend_reject", {coin_reject, credit}, {1'b1, 4'd0});
        for (int i = 0; i < 14; i++) tick();
        chk("c4_pre_timeout", {vend_req, fault}, 2'b10);
        tick();
        chk("c4_timeout", {vend_req, fault, busy}, 3'b011);
        chk("c4_refund", credit, 4);
        drain("c4", 4);
        chk("c4_fault_once", fault, 0);
        put_coin(2'b10);
        put_coin(2'b10);
        cancel = 1'b1;
        sel = 2'b01;
        coin = 2'b01;
        tick();
        cancel = 1'b0;
        sel = 2'b00;
        coin = 2'b00;
        chk("c5_refund", {vend_req, busy, coin_reject}, 3'b011);
        chk("c5_credit", credit, 4);
        drain("c5", 4);
        put_coin(2'b10);
        put_coin(2'b01);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("c6_change", {busy, credit}, {1'b1, 4'd3});
        rstn = 1'b0;
        tick();
        chk("c6_rst", {credit, change_pulse, busy}, 0);
        rstn = 1'b1;
        tick();
        tick();
        chk("c6_quiet", {credit, change_pulse, busy}, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vending_dispense_ctrl.md
VENDING_DISPENSE_CTRL -- requirements
Module: vending_dispense_ctrl

Interface
REQ-001 Parameters SHALL be one per line:
- PRICE_A, 3, price of product A in 0.5-unit coins
- PRICE_B, 4, price of product B in 0.5-unit coins
- CREDIT_MAX, 12, maximum credit held, in 0.5 units
- TIMEOUT, 16, cycles allowed for vend_ack after vend_req rises
REQ-002 Ports SHALL be one per line:
- clk  in  1  single clock, rising edge
- rstn  in  1  synchronous active-low reset
- coin  in  2  01 = 0.5 coin, 10 = 1.0 coin, 00/11 = no coin; valid one cycle per coin
- sel  in  2  01 = product A, 10 = product B, 00/11 = none; one-cycle pulse
- cancel  in  1  one-cycle refund request
- vend_ack  in  1  dispenser done
- vend_req  out  1  dispense request, held until ack
- change_pulse  out  1  one pulse per 0.5 unit returned
- coin_reject  out  1  one-cycle pulse, coin refused (physically returned)
- fault  out  1  one-cycle pulse on dispenser timeout
- credit  out  4  current credit, 0.5 units
- busy  out  1  high in VEND or CHANGE
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-low on rstn.

Function
REQ-004 States SHALL be IDLE (credit 0), CREDIT (credit > 0), VEND, CHANGE; all outputs registered.
REQ-005 In IDLE/CREDIT, a valid coin SHALL add 1 or 2 to credit at the next edge; if the result would exceed CREDIT_MAX, credit SHALL be unchanged and coin_reject SHALL pulse the next cycle.
REQ-006 In VEND/CHANGE every valid coin SHALL be rejected (coin_reject pulse, credit unchanged).
REQ-007 Same-cycle priority in IDLE/CREDIT: cancel > sel > coin; a coin that loses to cancel or sel SHALL be rejected.
REQ-008 sel in CREDIT with credit >= price SHALL, at the next edge, enter VEND, assert vend_req, and set credit = credit - price; with insufficient credit, or sel 00/11, sel SHALL be ignored.
REQ-009 In VEND, vend_req SHALL stay high until vend_ack is sampled high; at that edge vend_req drops, and the state goes to CHANGE if credit > 0, else IDLE.
REQ-010 vend_ack outside VEND SHALL be ignored.
REQ-011 If vend_ack is not sampled within TIMEOUT cycles of vend_req rising, then at edge TIMEOUT:
- vend_req drops
- fault pulses one cycle
- credit is restored by the price (full refund)
- state goes to CHANGE
REQ-012 cancel in CREDIT SHALL enter CHANGE; cancel in IDLE, VEND or CHANGE SHALL be ignored.
REQ-013 In CHANGE, change_pulse SHALL alternate high one cycle and low one cycle, starting the cycle after entry, and credit SHALL decrement by 1 on each high cycle.
REQ-014 When the pulse that takes credit to 0 is issued, the state SHALL return to IDLE at the following edge.
REQ-015 credit SHALL never exceed CREDIT_MAX nor wrap below 0.
REQ-016 busy SHALL be high exactly while the state is VEND or CHANGE.

Reset
REQ-017 With rstn low at a rising edge, the following SHALL all be 0 at that edge:
- state (IDLE)
- credit
- timeout counter
- vend_req, change_pulse, coin_reject, fault, busy
REQ-018 Reset mid-VEND or mid-CHANGE SHALL abandon the operation: no further pulses, and remaining credit is discarded.

Verification
REQ-019 The bench SHALL cover:
- coins 01, 10, 10 (credit 5), then sel 01 -> vend_req next cycle, credit 2; ack after 3 cycles -> CHANGE, two change_pulse, each one cycle high, then IDLE.
- coins 10 x6 (credit 12), then coin 01 -> coin_reject one cycle, credit stays 12.
- credit 2, sel 10 -> ignored, state CREDIT, credit 2; then cancel -> 2 change_pulse, then IDLE.
- credit 4, sel 10, no ack -> after 16 cycles: fault pulse, vend_req low, credit 4, then 4 change_pulse.
- credit 4, cancel + sel 01 + coin 01 in the same cycle -> refund path taken, coin_reject pulse, no vend_req.
- rstn low during CHANGE with credit 3 -> next edge: credit 0, change_pulse 0, busy 0, IDLE.
